weight_fetcher: RTL and testbench
=================================

Name: weight_fetcher

Overview:
Read-side stage directly downstream of the weight cache SRAM. On a start command it streams a contiguous run of weight words out of the cache and presents them to the PE array on a valid/ready interface. A 2-entry output FIFO absorbs the SRAM's one-cycle registered-address read latency so that back-pressure never loses data. With w_ready held high, throughput is one word per cycle.

Parameters:
ADDR_WIDTH, 8, weight cache address width
DATA_WIDTH, 32, weight word width
MEM_DEPTH, 256, cache depth in words; addresses wrap modulo MEM_DEPTH

Ports:
clk  input  1  single clock for all logic
rst  input  1  synchronous reset, active-high
start  input  1  command strobe; sampled only in IDLE
base_addr  input  ADDR_WIDTH  first word address, captured with start
len  input  ADDR_WIDTH+1  word count, 0..MEM_DEPTH, captured with start
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when the run completes
sram_addr  output  ADDR_WIDTH  read address to the cache
sram_cs_n  output  1  cache chip select, active-low; low only on issue cycles
sram_wr_n  output  1  cache write enable, active-low; constant 1
sram_rdata  input  DATA_WIDTH  cache read data; valid the cycle after issue
w_data  output  DATA_WIDTH  weight word to the PE array
w_valid  output  1  w_data is valid
w_ready  input  1  PE array accepts; a beat transfers when w_valid && w_ready
w_last  output  1  marks the final beat of a run

Behaviour:
- Reset (rst=1 at a clk edge): FSM goes to IDLE; FIFO is emptied; issue and beat counters are cleared; the in-flight flag is cleared.
- Reset values: busy=0, done=0, w_valid=0, w_last=0, w_data=0, sram_addr=0, sram_cs_n=1, sram_wr_n=1.
- Reset mid-run abandons the run. No done pulse follows. Any SRAM read still in flight is discarded.
- FSM states: IDLE, RUN, FIN.
  - IDLE to RUN: start=1 and len!=0. The block captures base_addr and len, and busy rises on the next cycle.
  - IDLE to FIN: start=1 and len==0. No reads are issued and no beats are produced.
  - RUN to FIN: the beat with w_last=1 is accepted.
  - FIN to IDLE: always, after one cycle. done=1 for exactly that cycle and busy=0 in it.
  - start is ignored outside IDLE.
- Issue: in RUN, a read is issued in a cycle when issued<len and (fifo_count + inflight - pop) < 2.
  - pop = w_valid && w_ready in that cycle.
  - inflight = a read was issued in the previous cycle.
  - On issue: sram_cs_n=0 and sram_addr=(base_addr+issued) mod MEM_DEPTH. ADDR_WIDTH overflow wrap is intended.
- Capture: the cycle after an issue, sram_rdata is pushed into the FIFO. The FIFO is never pushed when full; the credit rule guarantees this.
- Output: w_data and w_valid come from the FIFO head.
  - w_data holds stable while w_valid=1 and w_ready=0.
  - w_last=1 together with w_valid exactly on beat number len-1. Beats are counted from 0.
- Latency: start is sampled at edge E0. The first read is issued in cycle 1, the data is captured at the end of cycle 2, and the first w_valid is in cycle 3.
- Steady state: with w_ready=1 the block issues every cycle and delivers one beat per cycle.
- FIFO full/empty:
  - Pop and push in the same cycle are allowed.
  - When w_ready stays low, issuing stops once FIFO count + inflight reaches 2. Nothing is dropped.
- len=MEM_DEPTH reads every word exactly once, starting at base_addr and wrapping.

Test Plan:
- Basic run: reset; base_addr=0x10, len=4, w_ready=1, cache[0x10..0x13]=A0..A3 -> w_valid in cycles 3..6 with A0..A3; w_last on A3; done pulse in cycle 7; busy high in cycles 1..6.
- Wrap-around: base_addr=0xFE, len=4 -> sram_addr sequence 0xFE,0xFF,0x00,0x01; beats arrive in that order.
- Back-pressure: len=8, w_ready toggling 1,0,0,1,... -> all 8 words delivered once, in order; w_data is stable during stalls; there are never more than 2 reads ahead of the consumer.
- Zero length and ignored start: len=0 -> done next cycle, no sram_cs_n=0, no w_valid. A start pulsed during RUN is ignored, and the current run completes unchanged.
- Reset mid-run: assert rst during beat 2 of a len=6 run -> the next cycle shows all outputs at reset values; no done pulse. A fresh start then runs correctly.
- Full cache: base_addr=0x80, len=256, w_ready=1 -> 256 consecutive beats with no bubbles; w_last on the word from address 0x7F.

Source files
------------

// File: rtl/weight_fetcher.sv
// Weight cache read stage: streams a contiguous run of words out of the
// weight SRAM to the PE array through a 2-entry FIFO sized for read latency.
module weight_fetcher #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  sram_cs_n,
    output logic                  sram_wr_n,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_valid,
    input  logic                  w_ready,
    output logic                  w_last
);

    localparam int LW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LW-1:0]           len_q, len_d;
    logic [LW-1:0]           issued_q, issued_d;
    logic [LW-1:0]           beat_q, beat_d;
    logic                    inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0]   mem_q [2];
    logic [DATA_WIDTH-1:0]   mem_d [2];
    logic                    wr_ptr_q, wr_ptr_d;
    logic                    rd_ptr_q, rd_ptr_d;
    logic [1:0]              count_q, count_d;

    logic                    pop;
    logic                    push;
    logic                    issue;
    logic                    last_beat;
    logic [2:0]              occ;

    always_comb begin
        pop       = (count_q != 2'd0) && w_ready;
        push      = inflight_q;
        // Occupancy the FIFO will have once everything in flight lands.
        occ       = 3'(count_q) + 3'(inflight_q) - 3'(pop);
        issue     = (state_q == RUN) && (issued_q < len_q) && (occ < 3'd2);
        last_beat = pop && (beat_q == len_q - LW'(1));

        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        issued_d   = issued_q;
        beat_d     = beat_q;
        inflight_d = issue;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q + 2'(push) - 2'(pop);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d   = base_addr;
                    len_d    = len;
                    issued_d = '0;
                    beat_d   = '0;
                    state_d  = (len == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (last_beat) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (issue) begin
            addr_d   = (addr_q == ADDR_MAX) ? '0 : addr_q + ADDR_WIDTH'(1);
            issued_d = issued_q + LW'(1);
        end

        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
            beat_d   = beat_q + LW'(1);
        end

        if (push) begin
            mem_d[wr_ptr_q] = sram_rdata;
            wr_ptr_d        = ~wr_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            beat_q     <= '0;
            inflight_q <= 1'b0;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            beat_q     <= beat_d;
            inflight_q <= inflight_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == FIN);
    assign sram_addr = addr_q;
    assign sram_cs_n = ~issue;
    assign sram_wr_n = 1'b1;
    assign w_valid   = (count_q != 2'd0);
    assign w_data    = mem_q[rd_ptr_q];
    assign w_last    = w_valid && (beat_q == len_q - LW'(1));

    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst)
        push |-> (count_q != 2'd2) || pop
    );

endmodule

// File: tb/tb_weight_fetcher.sv
// Scoreboard bench for weight_fetcher: SRAM model, expected beats queued at
// start, compared as the PE-side handshake accepts them.
module tb_weight_fetcher;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int MD = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic [AW-1:0] sram_addr;
    logic          sram_cs_n;
    logic          sram_wr_n;
    logic [DW-1:0] sram_rdata;
    logic [DW-1:0] w_data;
    logic          w_valid;
    logic          w_ready;
    logic          w_last;

    weight_fetcher #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MEM_DEPTH (MD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .sram_addr (sram_addr),
        .sram_cs_n (sram_cs_n),
        .sram_wr_n (sram_wr_n),
        .sram_rdata(sram_rdata),
        .w_data    (w_data),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_last    (w_last)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] cache [MD];

    always @(posedge clk) begin
        if (!sram_cs_n) sram_rdata <= cache[sram_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [DW-1:0] exp_data [$];
    logic          exp_last [$];
    logic [AW-1:0] addr_log [$];

    int            cs_tot = 0;
    int            beat_tot = 0;
    int            valid_tot = 0;
    int            done_tot = 0;
    int            iss_run = 0;
    int            pop_run = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] sb_d;
    logic          sb_l;
    int            ready_mode = 0;
    int            rdy_idx = 0;

    // Monitor / scoreboard
    initial forever begin
        @(negedge clk);
        if (rst) begin
            iss_run    = 0;
            pop_run    = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", w_valid, 1);
                check("hold_data", w_data, prev_data);
            end
            if (!sram_cs_n) begin
                cs_tot++;
                iss_run++;
                addr_log.push_back(sram_addr);
            end
            if (w_valid) valid_tot++;
            if (done) done_tot++;
            if (w_valid && w_ready) begin
                beat_tot++;
                pop_run++;
                check("sb_nonempty", exp_data.size() != 0, 1);
                if (exp_data.size() != 0) begin
                    sb_d = exp_data.pop_front();
                    sb_l = exp_last.pop_front();
                    check("beat_data", w_data, sb_d);
                    check("beat_last", w_last, sb_l);
                end
            end
            if (!sram_cs_n) check("reads_ahead", (iss_run - pop_run) <= 2, 1);
            prev_stall = w_valid && !w_ready;
            prev_data  = w_data;
        end
    end

    // Consumer ready pattern: always 1, or 1,0,0 repeating
    initial begin
        w_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) begin
                w_ready = 1'b1;
            end else begin
                w_ready = (rdy_idx % 3 == 0);
                rdy_idx++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic start_run(input logic [AW-1:0] b, input int n,
                             input bit expect_it);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = b;
        len       = (AW + 1)'(n);
        if (expect_it) begin
            for (int i = 0; i < n; i++) begin
                exp_data.push_back(cache[AW'(int'(b) + i)]);
                exp_last.push_back(i == n - 1);
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        check({tag, "_done_seen"}, seen, 1);
        if (seen) begin
            check({tag, "_busy_at_done"}, busy, 0);
            @(negedge clk);
            check({tag, "_done_pulse"}, done, 0);
        end
        check({tag, "_sb_empty"}, exp_data.size(), 0);
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_done"}, done, 0);
        check({pfx, "_w_valid"}, w_valid, 0);
        check({pfx, "_w_last"}, w_last, 0);
        check({pfx, "_w_data"}, w_data, 0);
        check({pfx, "_sram_addr"}, sram_addr, 0);
        check({pfx, "_sram_cs_n"}, sram_cs_n, 1);
        check({pfx, "_sram_wr_n"}, sram_wr_n, 1);
    endtask

    int b0, c0, v0, d0, gaps;
    logic [AW-1:0] wexp [4];

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        len       = '0;
        for (int i = 0; i < MD; i++) cache[i] = $urandom;
        for (int i = 0; i < 4; i++) cache[AW'(8'h10 + i)] = 32'hA0A0_0000 | i;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic run, cycle-exact
        start_run(8'h10, 4, 1);
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            check("basic_busy", busy, (n <= 6));
            check("basic_valid", w_valid, (n >= 3 && n <= 6));
            check("basic_done", done, (n == 7));
            check("basic_cs_n", sram_cs_n, !(n <= 4));
            check("basic_last", w_last, (n == 6));
            if (n >= 3 && n <= 6)
                check("basic_data", w_data, 32'hA0A0_0000 | (n - 3));
        end
        check("basic_sb_empty", exp_data.size(), 0);

        // Address wrap
        addr_log.delete();
        start_run(8'hFE, 4, 1);
        wait_done(20, "wrap");
        wexp = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        check("wrap_nreads", addr_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < addr_log.size()) check("wrap_addr", addr_log[i], wexp[i]);
        end

        // Back-pressure
        ready_mode = 1;
        rdy_idx    = 0;
        b0 = beat_tot;
        c0 = cs_tot;
        start_run(8'h40, 8, 1);
        wait_done(100, "bp");
        check("bp_beats", beat_tot - b0, 8);
        check("bp_reads", cs_tot - c0, 8);
        ready_mode = 0;

        // Zero length
        c0 = cs_tot;
        v0 = valid_tot;
        start_run(8'h00, 0, 1);
        @(negedge clk);
        check("zl_done", done, 1);
        check("zl_busy", busy, 0);
        repeat (3) @(negedge clk);
        check("zl_done_off", done, 0);
        check("zl_no_reads", cs_tot - c0, 0);
        check("zl_no_valid", valid_tot - v0, 0);

        // Start pulsed during RUN is ignored
        b0 = beat_tot;
        c0 = cs_tot;
        start_run(8'h20, 5, 1);
        repeat (2) @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = 8'h90;
        len       = 9'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(40, "ign");
        check("ign_beats", beat_tot - b0, 5);
        check("ign_reads", cs_tot - c0, 5);
        d0 = done_tot;
        repeat (4) @(negedge clk);
        check("ign_idle_busy", busy, 0);
        check("ign_no_extra_done", done_tot - d0, 0);

        // Reset during beat 2 of a len=6 run
        start_run(8'h30, 6, 1);
        repeat (5) @(negedge clk);
        check("midrst_beat2_valid", w_valid, 1);
        check("midrst_beat2_data", w_data, cache[8'h32]);
        rst = 1'b1;
        d0  = done_tot;
        @(negedge clk);
        check_reset("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_data.delete();
        exp_last.delete();
        repeat (5) @(negedge clk);
        check("midrst_no_done", done_tot - d0, 0);
        check("midrst_idle", busy, 0);
        start_run(8'h30, 3, 1);
        wait_done(20, "post_rst");

        // Full cache, no bubbles
        b0 = beat_tot;
        c0 = cs_tot;
        start_run(8'h80, 256, 1);
        for (int k = 0; k < 10 && !w_valid; k++) @(negedge clk);
        check("full_first_valid", w_valid, 1);
        gaps = 0;
        for (int i = 0; i < 255; i++) begin
            @(negedge clk);
            if (!w_valid) gaps++;
        end
        check("full_no_bubbles", gaps, 0);
        check("full_last_flag", w_last, 1);
        check("full_last_word", w_data, cache[8'h7F]);
        wait_done(10, "full");
        check("full_beats", beat_tot - b0, 256);
        check("full_reads", cs_tot - c0, 256);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
